vote_controller: RTL and testbench
==================================

VOTE_CONTROLLER -- requirements
Module: vote_controller

Interface
REQ-001 Parameter DWELL_CYCLES, default 100_000_000, number of clk cycles each party figure is shown in auto-cycle result mode.
REQ-002 Parameter ACK_CYCLES, default 50_000_000, number of clk cycles the voted indication is held after a cast.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 mode  input  1  0 = voting mode, 1 = result mode; synchronous level.
REQ-006 ballot_en  input  1  officer arm request; rising edge issues one ballot.
REQ-007 btn_bjp, btn_cong, btn_nota  input  1 each  debounced party buttons; rising edge = press.
REQ-008 btn_next  input  1  debounced; rising edge advances the displayed party in result mode.
REQ-009 auto_cycle  input  1  1 = result mode advances every DWELL_CYCLES; 0 = advances only on btn_next.
REQ-010 bjp_count, cong_count, nota_count  output  10 each  per-party vote tallies.
REQ-011 bjp_fig, cong_fig, nota_fig  output  1 each  one-hot display select for the digit converter.
REQ-012 ready_led  output  1  ballot armed, waiting for a press.
REQ-013 voted_led  output  1  vote accepted, held for ACK_CYCLES.
REQ-014 error_led  output  1  multi-press rejected; cleared on next accepted vote or on disarm.

Function
REQ-015 A rising-edge detector (registered previous value) SHALL apply to ballot_en, each party button and btn_next; level-held inputs SHALL produce one event.
REQ-016 FSM states SHALL be IDLE, ARMED, ACK and RESULT.
REQ-017 IDLE: ballot_en edge with mode=0 -> ARMED; mode=1 -> RESULT.
REQ-018 ARMED: ready_led=1; exactly one party press edge in a cycle -> increment that tally, set voted_led, go to ACK.
REQ-019 ARMED: two or more party press edges in the same cycle -> no tally change, error_led=1, remain ARMED.
REQ-020 ARMED: mode=1 -> disarm, go to RESULT with no tally change (ballot forfeited), error_led cleared.
REQ-021 ACK: voted_led=1 for exactly ACK_CYCLES cycles, all presses ignored, then -> IDLE; a new ballot SHALL require a fresh ballot_en edge.
REQ-022 IDLE and ACK: party presses SHALL be ignored (one vote per ballot).
REQ-023 Tallies SHALL saturate at 1023; a press at 1023 is accepted (voted_led asserted) but the count stays 1023.
REQ-024 RESULT: exactly one fig output high, order BJP -> CONG -> NOTA -> BJP; entry shows BJP.
REQ-025 RESULT: advance on btn_next edge; if auto_cycle=1 also advance when the dwell counter reaches DWELL_CYCLES-1; the dwell counter restarts at 0 on every advance.
REQ-026 RESULT: mode=0 -> IDLE, all fig outputs 0 in the next cycle.
REQ-027 Outside RESULT, all fig outputs SHALL be 0, so the digit converter displays 0.
REQ-028 Tallies SHALL change only in the ARMED -> ACK transition.

Reset
REQ-029 Reset SHALL force IDLE, all tallies 0, all fig outputs 0, ready_led, voted_led and error_led 0, and clear the dwell counter, ACK counter and edge-detect registers.
REQ-030 Reset asserted in ARMED or ACK SHALL discard the pending ballot; no partial tally update.
REQ-031 Edge-detect registers SHALL reset to 0, so an input held high through reset deassertion counts as one edge on the first clock.

Structure
REQ-032 State encoding, party index constants (BJP=0, CONG=1, NOTA=2) and the 1023 saturation limit SHALL live in a shared package voting_pkg.
REQ-033 The result-mode display sequencer (one-hot rotation plus dwell counter) SHALL be a sub-module named display_sequencer.
REQ-034 The fig outputs SHALL connect directly to the existing digit converter's select inputs and the tallies to its count inputs.

Verification (ACK_CYCLES=4, DWELL_CYCLES=8)
REQ-035 Reset; ballot_en edge; btn_cong edge -> cong_count=1, voted_led high 4 cycles, then IDLE with ready_led=0.
REQ-036 Armed; btn_bjp and btn_nota edge in the same cycle -> counts unchanged, error_led=1; then btn_nota alone -> nota_count=1, error_led=0.
REQ-037 Press btn_bjp 3 times without ballot_en -> bjp_count=0; a press during ACK -> no second increment.
REQ-038 Preload bjp_count to 1023 via 1023 ballots; one more ballot plus btn_bjp -> count stays 1023, voted_led asserted.
REQ-039 mode=1, auto_cycle=1 -> bjp_fig for 8 cycles, cong_fig for 8, nota_fig for 8, then bjp_fig; btn_next mid-dwell advances immediately and restarts the dwell.
REQ-040 Reset asserted in ACK after a nota vote -> all tallies 0, IDLE, voted_led=0.

Source files
------------

// File: rtl/voting_pkg.sv
// Shared constants for the vote controller: FSM encodings, party indices,
// display one-hot patterns and the tally saturation limit.
package voting_pkg;

  // FSM state encodings, kept as plain constants for legacy compatibility
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_ACK    = 2'd2;
  localparam logic [1:0] ST_RESULT = 2'd3;

  // Party indices into press vectors, tally arrays and the fig vector
  localparam int unsigned PARTY_BJP   = 0;
  localparam int unsigned PARTY_CONG  = 1;
  localparam int unsigned PARTY_NOTA  = 2;
  localparam int unsigned NUM_PARTIES = 3;

  // One-hot display selects, bit position equals party index
  localparam logic [NUM_PARTIES-1:0] FIG_BJP  = 3'b001;
  localparam logic [NUM_PARTIES-1:0] FIG_CONG = 3'b010;
  localparam logic [NUM_PARTIES-1:0] FIG_NOTA = 3'b100;

  // Tally width and saturation limit
  localparam int unsigned COUNT_W   = 10;
  localparam logic [COUNT_W-1:0] TALLY_MAX = 10'd1023;

  typedef logic [COUNT_W-1:0] tally_t;

  // Increment that sticks at the saturation limit
  function automatic tally_t sat_inc(input tally_t v);
    return (v == TALLY_MAX) ? v : v + 1'b1;
  endfunction

  // Number of simultaneous party press events (0..3)
  function automatic logic [1:0] count_presses(input logic [NUM_PARTIES-1:0] p);
    return {1'b0, p[0]} + {1'b0, p[1]} + {1'b0, p[2]};
  endfunction

endpackage

// File: rtl/vote_controller_display_sequencer.sv
// Result-mode display sequencer: rotates a one-hot party select
// BJP -> CONG -> NOTA -> BJP on a manual advance or, when auto mode is on,
// after the dwell counter has covered DWELL_CYCLES cycles.
module display_sequencer
  import voting_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 100_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en_i,
  input  logic                   next_i,
  input  logic                   auto_i,
  output logic [NUM_PARTIES-1:0] fig_o
);

  localparam int unsigned DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_CYCLES - 1);

  logic [NUM_PARTIES-1:0] sel_q, sel_d;
  logic [DW_W-1:0]        dwell_q, dwell_d;
  logic                   advance;

  // Next rotation/dwell values; disabled sequencer parks on BJP with dwell cleared
  always_comb begin
    sel_d   = sel_q;
    dwell_d = dwell_q;
    advance = 1'b0;
    if (!en_i) begin
      sel_d   = FIG_BJP;
      dwell_d = '0;
    end else begin
      advance = next_i | (auto_i & (dwell_q == DWELL_LAST));
      if (advance) begin
        sel_d   = {sel_q[NUM_PARTIES-2:0], sel_q[NUM_PARTIES-1]};
        dwell_d = '0;
      end else if (auto_i) begin
        dwell_d = dwell_q + 1'b1;
      end else begin
        dwell_d = '0;
      end
    end
  end

  // Rotation and dwell registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q   <= FIG_BJP;
      dwell_q <= '0;
    end else begin
      sel_q   <= sel_d;
      dwell_q <= dwell_d;
    end
  end

  assign fig_o = en_i ? sel_q : '0;

endmodule

// File: rtl/vote_controller.sv
// Electronic voting controller: officer-armed single ballots, per-party
// saturating tallies, multi-press rejection and a result display mode.
module vote_controller
  import voting_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 100_000_000,
  parameter int unsigned ACK_CYCLES   = 50_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic               ballot_en,
  input  logic               btn_bjp,
  input  logic               btn_cong,
  input  logic               btn_nota,
  input  logic               btn_next,
  input  logic               auto_cycle,
  output logic [COUNT_W-1:0] bjp_count,
  output logic [COUNT_W-1:0] cong_count,
  output logic [COUNT_W-1:0] nota_count,
  output logic               bjp_fig,
  output logic               cong_fig,
  output logic               nota_fig,
  output logic               ready_led,
  output logic               voted_led,
  output logic               error_led
);

  localparam int unsigned ACK_W = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_CYCLES - 1);

  logic [1:0]             state_q, state_d;
  logic [ACK_W-1:0]       ack_q, ack_d;
  logic                   error_q, error_d;
  tally_t                 tally_q [NUM_PARTIES];
  tally_t                 tally_d [NUM_PARTIES];

  logic                   ballot_prev_q, next_prev_q;
  logic [NUM_PARTIES-1:0] press_prev_q;
  logic [NUM_PARTIES-1:0] press_raw, press_edge;
  logic                   ballot_edge, next_edge;
  logic [1:0]             n_press;
  logic                   in_result;
  logic [NUM_PARTIES-1:0] fig;

  // Gather party buttons into an index-ordered vector
  always_comb begin
    press_raw             = '0;
    press_raw[PARTY_BJP]  = btn_bjp;
    press_raw[PARTY_CONG] = btn_cong;
    press_raw[PARTY_NOTA] = btn_nota;
  end

  // Previous-value registers for rising-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ballot_prev_q <= 1'b0;
      next_prev_q   <= 1'b0;
      press_prev_q  <= '0;
    end else begin
      ballot_prev_q <= ballot_en;
      next_prev_q   <= btn_next;
      press_prev_q  <= press_raw;
    end
  end

  assign ballot_edge = ballot_en & ~ballot_prev_q;
  assign next_edge   = btn_next & ~next_prev_q;
  assign press_edge  = press_raw & ~press_prev_q;
  assign n_press     = count_presses(press_edge);

  // Ballot FSM next-state, ACK timer, error flag and tally updates
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    error_d = error_q;
    for (int unsigned i = 0; i < NUM_PARTIES; i++) begin
      tally_d[i] = tally_q[i];
    end
    case (state_q)
      ST_IDLE: begin
        ack_d = '0;
        if (ballot_edge) begin
          state_d = mode ? ST_RESULT : ST_ARMED;
        end
      end
      ST_ARMED: begin
        ack_d = '0;
        if (mode) begin
          // switching to results forfeits the armed ballot
          state_d = ST_RESULT;
          error_d = 1'b0;
        end else if (n_press == 2'd1) begin
          state_d = ST_ACK;
          error_d = 1'b0;
          for (int unsigned i = 0; i < NUM_PARTIES; i++) begin
            if (press_edge[i]) begin
              tally_d[i] = sat_inc(tally_q[i]);
            end
          end
        end else if (n_press > 2'd1) begin
          error_d = 1'b1;
        end
      end
      ST_ACK: begin
        if (ack_q == ACK_LAST) begin
          state_d = ST_IDLE;
          ack_d   = '0;
        end else begin
          ack_d = ack_q + 1'b1;
        end
      end
      ST_RESULT: begin
        ack_d = '0;
        if (!mode) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ack_d   = '0;
        error_d = 1'b0;
      end
    endcase
  end

  // FSM, timer, error and tally registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ack_q   <= '0;
      error_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_PARTIES; i++) begin
        tally_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      error_q <= error_d;
      for (int unsigned i = 0; i < NUM_PARTIES; i++) begin
        tally_q[i] <= tally_d[i];
      end
    end
  end

  assign in_result = (state_q == ST_RESULT);

  display_sequencer #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_display_sequencer (
    .clk   (clk),
    .reset (reset),
    .en_i  (in_result),
    .next_i(next_edge),
    .auto_i(auto_cycle),
    .fig_o (fig)
  );

  assign bjp_fig    = fig[PARTY_BJP];
  assign cong_fig   = fig[PARTY_CONG];
  assign nota_fig   = fig[PARTY_NOTA];
  assign bjp_count  = tally_q[PARTY_BJP];
  assign cong_count = tally_q[PARTY_CONG];
  assign nota_count = tally_q[PARTY_NOTA];
  assign ready_led  = (state_q == ST_ARMED);
  assign voted_led  = (state_q == ST_ACK);
  assign error_led  = error_q;

endmodule

// File: tb/tb_vote_controller.sv
// Directed bench for vote_controller with ACK_CYCLES=4, DWELL_CYCLES=8.
module tb_vote_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       mode, ballot_en, btn_bjp, btn_cong, btn_nota, btn_next, auto_cycle;
  logic [9:0] bjp_count, cong_count, nota_count;
  logic       bjp_fig, cong_fig, nota_fig;
  logic       ready_led, voted_led, error_led;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vote_controller #(
    .DWELL_CYCLES(8),
    .ACK_CYCLES  (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .ballot_en (ballot_en),
    .btn_bjp   (btn_bjp),
    .btn_cong  (btn_cong),
    .btn_nota  (btn_nota),
    .btn_next  (btn_next),
    .auto_cycle(auto_cycle),
    .bjp_count (bjp_count),
    .cong_count(cong_count),
    .nota_count(nota_count),
    .bjp_fig   (bjp_fig),
    .cong_fig  (cong_fig),
    .nota_fig  (nota_fig),
    .ready_led (ready_led),
    .voted_led (voted_led),
    .error_led (error_led)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] figs();
    return {29'd0, nota_fig, cong_fig, bjp_fig};
  endfunction

  function automatic logic [31:0] counts();
    return {2'd0, bjp_count, cong_count, nota_count};
  endfunction

  // Full ballot with one party press, no checks (used for bulk preload)
  task automatic cast_bjp_quiet();
    ballot_en = 1'b1; tick();
    ballot_en = 1'b0; btn_bjp = 1'b1; tick();
    btn_bjp = 1'b0;
    repeat (4) tick();
  endtask

  // After the accepting edge: voted stays for 3 more samples, then IDLE
  task automatic check_ack_tail(input string tag);
    for (int k = 0; k < 3; k++) begin
      tick();
      check({tag, "_voted_hold"}, {31'd0, voted_led}, 32'd1);
    end
    tick();
    check({tag, "_voted_drop"}, {31'd0, voted_led}, 32'd0);
    check({tag, "_ready_idle"}, {31'd0, ready_led}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mode = 1'b0; ballot_en = 1'b0; btn_bjp = 1'b0; btn_cong = 1'b0;
    btn_nota = 1'b0; btn_next = 1'b0; auto_cycle = 1'b0;
    tick(); tick();
    check("rst_counts", counts(), 32'd0);
    check("rst_figs", figs(), 32'd0);
    check("rst_leds", {29'd0, ready_led, voted_led, error_led}, 32'd0);
    #3 reset = 1'b0;
    tick();

    // single cong vote
    ballot_en = 1'b1; tick();
    check("arm_ready", {31'd0, ready_led}, 32'd1);
    ballot_en = 1'b0; btn_cong = 1'b1; tick();
    btn_cong = 1'b0;
    check("cong_vote", counts(), {2'd0, 10'd0, 10'd1, 10'd0});
    check("cong_voted", {31'd0, voted_led}, 32'd1);
    check_ack_tail("cong");

    // double press rejected, then single nota accepted
    ballot_en = 1'b1; tick();
    ballot_en = 1'b0; btn_bjp = 1'b1; btn_nota = 1'b1; tick();
    btn_bjp = 1'b0; btn_nota = 1'b0;
    check("multi_counts", counts(), {2'd0, 10'd0, 10'd1, 10'd0});
    check("multi_error", {31'd0, error_led}, 32'd1);
    check("multi_ready", {31'd0, ready_led}, 32'd1);
    tick();
    btn_nota = 1'b1; tick();
    btn_nota = 1'b0;
    check("nota_vote", counts(), {2'd0, 10'd0, 10'd1, 10'd1});
    check("nota_error_clr", {31'd0, error_led}, 32'd0);
    check_ack_tail("nota");

    // presses without a ballot are ignored
    for (int k = 0; k < 3; k++) begin
      btn_bjp = 1'b1; tick();
      btn_bjp = 1'b0; tick();
    end
    check("no_ballot", {22'd0, bjp_count}, 32'd0);
    check("no_ballot_ready", {31'd0, ready_led}, 32'd0);

    // press during ACK ignored
    ballot_en = 1'b1; tick();
    ballot_en = 1'b0; btn_bjp = 1'b1; tick();
    check("bjp_vote", {22'd0, bjp_count}, 32'd1);
    btn_bjp = 1'b0; tick();
    btn_bjp = 1'b1; tick();
    btn_bjp = 1'b0; tick();
    tick();
    check("ack_press_ign", {22'd0, bjp_count}, 32'd1);
    check("ack_done", {31'd0, voted_led}, 32'd0);

    // saturation at 1023
    for (int k = 0; k < 1022; k++) cast_bjp_quiet();
    check("preload_1023", {22'd0, bjp_count}, 32'd1023);
    ballot_en = 1'b1; tick();
    ballot_en = 1'b0; btn_bjp = 1'b1; tick();
    btn_bjp = 1'b0;
    check("sat_count", {22'd0, bjp_count}, 32'd1023);
    check("sat_voted", {31'd0, voted_led}, 32'd1);
    repeat (4) tick();

    // auto-cycle result display
    mode = 1'b1; auto_cycle = 1'b1;
    ballot_en = 1'b1; tick();
    ballot_en = 1'b0;
    for (int s = 0; s < 25; s++) begin
      if (s < 8 || s == 24) check("auto_bjp", figs(), 32'd1);
      else if (s < 16)      check("auto_cong", figs(), 32'd2);
      else                  check("auto_nota", figs(), 32'd4);
      if (s != 24) tick();
    end
    repeat (3) tick();
    check("pre_next_bjp", figs(), 32'd1);
    btn_next = 1'b1; tick();
    btn_next = 1'b0;
    check("next_cong", figs(), 32'd2);
    for (int s = 1; s < 8; s++) begin
      tick();
      check("dwell_restart_cong", figs(), 32'd2);
    end
    tick();
    check("dwell_restart_nota", figs(), 32'd4);
    check("result_counts", counts(), {2'd0, 10'd1023, 10'd1, 10'd1});
    mode = 1'b0; tick();
    check("exit_figs", figs(), 32'd0);

    // disarm into result clears error and forfeits ballot
    ballot_en = 1'b1; tick();
    ballot_en = 1'b0; btn_bjp = 1'b1; btn_cong = 1'b1; tick();
    btn_bjp = 1'b0; btn_cong = 1'b0;
    check("disarm_err_set", {31'd0, error_led}, 32'd1);
    mode = 1'b1; tick();
    check("disarm_err_clr", {31'd0, error_led}, 32'd0);
    check("disarm_fig", figs(), 32'd1);
    check("disarm_counts", counts(), {2'd0, 10'd1023, 10'd1, 10'd1});
    mode = 1'b0; tick();

    // reset during ACK discards everything
    ballot_en = 1'b1; tick();
    ballot_en = 1'b0; btn_nota = 1'b1; tick();
    btn_nota = 1'b0;
    check("nota_vote2", {22'd0, nota_count}, 32'd2);
    tick();
    reset = 1'b1; #2;
    check("ack_rst_counts", counts(), 32'd0);
    check("ack_rst_leds", {29'd0, ready_led, voted_led, error_led}, 32'd0);
    check("ack_rst_figs", figs(), 32'd0);
    ballot_en = 1'b1;
    tick();
    #3 reset = 1'b0;
    tick();
    check("held_edge_arm", {31'd0, ready_led}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
